// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state type and widths for the 32-to-16-bit SRAM sequencer
package sram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 16;
  localparam int CPU_W = 32;
  localparam int DEF_BASE_ADDR = 1024;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter flagging the last cycle of each SRAM half-access
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);
  logic [2:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= 3'(WAIT_CYCLES);
    else if (cnt != 3'd0) cnt <= cnt - 3'd1;
  assign last = WAIT_CYCLES == 0 ? 1'b1 : cnt == 3'd0;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: splits a 32-bit load/store into low/high 16-bit SRAM accesses, stalling via ready
// Optional SRAM_CTRL_RANGE_CHECK_EN: out-of-window addresses complete without touching the SRAM.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int DEPTH_WORDS = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [CPU_W-1:0]   address,
  input  logic [CPU_W-1:0]   write_data,
  output logic [CPU_W-1:0]   read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif
  state_t state;
  logic is_wr, last, req, hit;
  logic [SRAM_DW-1:0] dq_out, wdata_hi;
  logic [CPU_W-1:0] off;
  assign req = wr_en | rd_en;
  assign off = address - CPU_W'(BASE_ADDR);
  assign hit = ~RANGE_CHECK | ((address >= CPU_W'(BASE_ADDR)) & (off < CPU_W'(4 * DEPTH_WORDS)));
  assign ready = (state == DONE) | ((state == IDLE) & ~req);
  assign SRAM_DQ = SRAM_WE_N ? 'z : dq_out;
  assign {SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N} = 4'b0000;
  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk(clk),
    .rst(rst),
    .load((state == IDLE) | ((state == LOW) & last)),
    .last(last)
  );
  // WE_N stays low across both halves of a store; the address LSB advances at the boundary
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      is_wr <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      dq_out <= '0;
      wdata_hi <= '0;
      read_data <= '0;
    end else
      case (state)
        IDLE: if (req) begin
          is_wr <= wr_en;
          dq_out <= write_data[15:0];
          wdata_hi <= write_data[31:16];
          if (hit) begin
            state <= LOW;
            SRAM_ADDR <= {(SRAM_AW - 1)'(off >> 2), 1'b0};
            SRAM_WE_N <= ~wr_en;
          end else begin
            state <= DONE;
            if (!wr_en) read_data <= '0;
          end
        end
        LOW: if (last) begin
          state <= HIGH;
          SRAM_ADDR[0] <= 1'b1;
          dq_out <= wdata_hi;
          if (!is_wr) read_data[15:0] <= SRAM_DQ;
        end
        HIGH: if (last) begin
          state <= DONE;
          SRAM_WE_N <= 1'b1;
          if (!is_wr) read_data[31:16] <= SRAM_DQ;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: two controllers (W=0 and W=2) against behavioural SRAMs and a word-level model
module tb_sram_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [2];
  logic wr [2];
  logic rd [2];
  logic [31:0] adr [2];
  logic [31:0] wd [2];
  wire [31:0] rdat [2];
  wire rdy [2];
  wire we [2];
  wire [18:0] sa [2];
  wire ub [2];
  wire lb [2];
  wire ce [2];
  wire oe [2];
  wire [15:0] dq0, dq1;
  logic [15:0] mem [2][256] = '{default: '0};
  logic [31:0] ref_m [2][32] = '{default: '0};
  logic [31:0] last_rd [2] = '{default: '0};
  int we_cnt [2] = '{default: 0};
  int errors = 0;
  int checks = 0;
  sram_controller #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst[0]), .wr_en(wr[0]), .rd_en(rd[0]), .address(adr[0]),
    .write_data(wd[0]), .read_data(rdat[0]), .ready(rdy[0]), .SRAM_DQ(dq0),
    .SRAM_ADDR(sa[0]), .SRAM_WE_N(we[0]), .SRAM_UB_N(ub[0]), .SRAM_LB_N(lb[0]),
    .SRAM_CE_N(ce[0]), .SRAM_OE_N(oe[0])
  );
  sram_controller #(.WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst[1]), .wr_en(wr[1]), .rd_en(rd[1]), .address(adr[1]),
    .write_data(wd[1]), .read_data(rdat[1]), .ready(rdy[1]), .SRAM_DQ(dq1),
    .SRAM_ADDR(sa[1]), .SRAM_WE_N(we[1]), .SRAM_UB_N(ub[1]), .SRAM_LB_N(lb[1]),
    .SRAM_CE_N(ce[1]), .SRAM_OE_N(oe[1])
  );
  // SRAM drives the bus whenever not being written; writes land mid-cycle
  assign dq0 = we[0] ? mem[0][sa[0][7:0]] : 'z;
  assign dq1 = we[1] ? mem[1][sa[1][7:0]] : 'z;
  always @(negedge clk) begin
    if (!we[0]) begin mem[0][sa[0][7:0]] <= dq0; we_cnt[0] <= we_cnt[0] + 1; end
    if (!we[1]) begin mem[1][sa[1][7:0]] <= dq1; we_cnt[1] <= we_cnt[1] + 1; end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic op(input int k, input logic w_, input logic r_, input logic [31:0] a,
                    input logic [31:0] d, input string tag, input bit oor);
    int n, idx, wc;
    logic [31:0] exp_rd;
    idx = oor ? 0 : int'((a - 32'd1024) >> 2);
    exp_rd = last_rd[k];
    wc = we_cnt[k];
    wr[k] = w_; rd[k] = r_; adr[k] = a; wd[k] = d;
    n = 0;
    #1;
    while (!rdy[k] && n < 40) begin n++; @(negedge clk); #1; end
    wr[k] = 1'b0; rd[k] = 1'b0;
    if (!w_ && r_) exp_rd = oor ? 32'h0 : ref_m[k][idx];
    else if (w_ && !oor) ref_m[k][idx] = d;
    last_rd[k] = exp_rd;
    check({tag, " stall"}, n, oor ? 1 : 3 + 4 * k);
    check({tag, " read_data"}, rdat[k], exp_rd);
    @(negedge clk);
    if (w_ && !oor) check({tag, " sram"}, {mem[k][2*idx+1], mem[k][2*idx]}, d);
    else check({tag, " we_n quiet"}, we_cnt[k], wc);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; wr[k] = 1'b0; rd[k] = 1'b0; adr[k] = '0; wd[k] = '0;
    end
    @(negedge clk); @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    check("rst read_data", rdat[0], 32'h0);
    check("rst addr", 32'(sa[0]), 32'h0);
    check("rst we_n", 32'(we[0]), 32'h1);
    check("rst ready", 32'(rdy[0]), 32'h1);
    check("tied pins", {28'h0, ub[0], lb[0], ce[0], oe[0]}, 32'h0);
    op(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "st0", 1'b0);
    check("st0 lo", 32'(mem[0][0]), 32'hBEEF);
    check("st0 hi", 32'(mem[0][1]), 32'hDEAD);
    op(0, 1'b0, 1'b1, 32'd1024, 32'h0, "ld0", 1'b0);
    op(0, 1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, "both", 1'b0);
    check("both lo", 32'(mem[0][4]), 32'h5A5A);
    check("both hi", 32'(mem[0][5]), 32'hA5A5);
    wr[0] = 1'b1; adr[0] = 32'd1024; wd[0] = 32'hFFFF0000;
    @(posedge clk); @(posedge clk);
    #1 rst[0] = 1'b1; wr[0] = 1'b0;
    #1 rst[0] = 1'b0;
    @(negedge clk);
    ref_m[0][0] = 32'hDEAD0000;
    last_rd[0] = 32'h0;
    check("midrst lo", 32'(mem[0][0]), 32'h0000);
    check("midrst hi", 32'(mem[0][1]), 32'hDEAD);
    check("midrst we_n", 32'(we[0]), 32'h1);
    check("midrst addr", 32'(sa[0]), 32'h0);
    check("midrst read_data", rdat[0], 32'h0);
    check("midrst ready", 32'(rdy[0]), 32'h1);
    op(1, 1'b1, 1'b0, 32'd1028, 32'h12345678, "st2", 1'b0);
    check("st2 lo", 32'(mem[1][2]), 32'h5678);
    check("st2 hi", 32'(mem[1][3]), 32'h1234);
    op(1, 1'b0, 1'b1, 32'd1028, 32'h0, "ld2", 1'b0);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    op(0, 1'b0, 1'b1, 32'd512, 32'h0, "oor", 1'b1);
`endif
    for (int i = 0; i < 48; i++) begin
      int k;
      logic w_;
      k = i % 2;
      w_ = 1'($urandom_range(0, 1));
      op(k, w_, ~w_, 32'd1024 + 32'(4 * $urandom_range(0, 31)), $urandom, "rnd", 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
